// File: rtl/usb_reg_burst_engine.sv
// usb_reg_burst_engine
//   Bus-master sequencer feeding the USB host-chip byte controller. One
//   command (register index, direction, length) becomes the chip's indexed
//   access sequence: an index write on a0=0 followed by data accesses on
//   a0=1. Write bytes are pulled from a valid/ready port and read bytes are
//   pushed to another, so buffer contents move without per-byte software
//   handshaking.
//
// Parameters
//   AUTO_INC : 1 = chip auto-increments its index, one index write per burst
//              0 = index write (reg+i) ahead of every data byte
//   TIMEOUT  : cycles a request may stay up without dn_stall rising
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_write, cmd_reg, cmd_len  direction, starting index, byte count
//   wr_valid/wr_ready/wr_data    write-byte stream into the engine
//   rd_valid/rd_ready/rd_data    read-byte stream out of the engine
//   busy, done, err              status; done/err are one-cycle pulses
//   dn_read, dn_write, dn_a0,
//   dn_wdata, dn_stall, dn_rdata downstream byte-controller handshake
module usb_reg_burst_engine #(
  parameter int AUTO_INC = 1,
  parameter int TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       dn_read,
  output logic       dn_write,
  output logic       dn_a0,
  output logic [7:0] dn_wdata,
  input  logic       dn_stall,
  input  logic [7:0] dn_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_IDX_REQ   = 3'd1;
  localparam logic [2:0] S_IDX_WAIT  = 3'd2;
  localparam logic [2:0] S_FETCH     = 3'd3;
  localparam logic [2:0] S_DATA_REQ  = 3'd4;
  localparam logic [2:0] S_DATA_WAIT = 3'd5;
  localparam logic [2:0] S_PUSH      = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  logic [2:0]    state;
  logic          is_write;
  logic [7:0]    idx;
  logic [7:0]    cnt;
  logic [TW-1:0] tmo;
  logic          err_q;
  logic [7:0]    wbyte;
  logic [7:0]    rbyte;

  logic in_req;
  assign in_req = (state == S_IDX_REQ) || (state == S_DATA_REQ);

  // Control path: state, counters, timeout and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      is_write <= 1'b0;
      idx      <= 8'd0;
      cnt      <= 8'd0;
      tmo      <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      // The timeout counter only runs while a request is up, so it restarts
      // from zero at every request assertion.
      if (!in_req) tmo <= '0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            is_write <= cmd_write;
            idx      <= cmd_reg;
            cnt      <= cmd_len;
            state    <= S_IDX_REQ;
          end
        end
        S_IDX_REQ, S_DATA_REQ: begin
          if (dn_stall) begin
            // Accepted: the request drops as we leave the REQ state.
            state <= (state == S_IDX_REQ) ? S_IDX_WAIT : S_DATA_WAIT;
          end else if (tmo == TMO_LAST) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        S_IDX_WAIT: begin
          if (!dn_stall) begin
            if (cnt == 8'd0)   state <= S_DONE;
            else if (is_write) state <= S_FETCH;
            else               state <= S_DATA_REQ;
          end
        end
        S_FETCH: begin
          if (wr_valid) state <= S_DATA_REQ;
        end
        S_DATA_WAIT: begin
          if (!dn_stall) begin
            cnt <= cnt - 8'd1;
            idx <= idx + 8'd1;
            if (!is_write)          state <= S_PUSH;
            else if (cnt == 8'd1)   state <= S_DONE;
            else if (AUTO_INC != 0) state <= S_FETCH;
            else                    state <= S_IDX_REQ;
          end
        end
        S_PUSH: begin
          // cnt was already decremented when the byte was captured.
          if (rd_ready) begin
            if (cnt == 8'd0)        state <= S_DONE;
            else if (AUTO_INC != 0) state <= S_DATA_REQ;
            else                    state <= S_IDX_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data path: byte holding registers, no reset (outputs are gated by state)
  always_ff @(posedge clk) begin
    if (state == S_FETCH && wr_valid) wbyte <= wr_data;
    if (state == S_DATA_WAIT && !dn_stall && !is_write) rbyte <= dn_rdata;
  end

  // Outputs decode straight from state so an asynchronous reset drops the
  // downstream request in the same instant.
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);
  assign wr_ready  = (state == S_FETCH);
  assign rd_valid  = (state == S_PUSH);
  assign rd_data   = (state == S_PUSH) ? rbyte : 8'd0;
  assign done      = (state == S_DONE);
  assign err       = err_q;
  assign dn_write  = (state == S_IDX_REQ) || (state == S_DATA_REQ && is_write);
  assign dn_read   = (state == S_DATA_REQ) && !is_write;
  assign dn_a0     = (state == S_DATA_REQ);
  assign dn_wdata  = (state == S_IDX_REQ) ? idx :
                     (state == S_DATA_REQ && is_write) ? wbyte : 8'd0;

endmodule

// File: tb/tb_usb_reg_burst_engine.sv
// Testbench for usb_reg_burst_engine: two instances (AUTO_INC=1 and 0)
// share stimulus; a downstream model, write feeder and read consumer run on
// the falling edge and check against scoreboard queues filled when each
// command is issued.
module tb_usb_reg_burst_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0] cmd_reg = 8'd0, cmd_len = 8'd0;
  logic       wr_valid = 1'b0, rd_ready = 1'b0, dn_stall = 1'b0;
  logic [7:0] wr_data = 8'd0, dn_rdata = 8'd0;

  logic       a_cmd_ready, a_wr_ready, a_rd_valid, a_busy, a_done, a_err;
  logic       a_dn_read, a_dn_write, a_dn_a0;
  logic [7:0] a_rd_data, a_dn_wdata;
  logic       b_cmd_ready, b_wr_ready, b_rd_valid, b_busy, b_done, b_err;
  logic       b_dn_read, b_dn_write, b_dn_a0;
  logic [7:0] b_rd_data, b_dn_wdata;
  logic       a_cmd_valid, b_cmd_valid, a_dn_stall, b_dn_stall;

  assign a_cmd_valid = cmd_valid & ~sel;
  assign b_cmd_valid = cmd_valid & sel;
  assign a_dn_stall  = dn_stall & ~sel;
  assign b_dn_stall  = dn_stall & sel;

  logic       cmd_ready, wr_ready, rd_valid, busy, done, err;
  logic       dn_read, dn_write, dn_a0;
  logic [7:0] rd_data, dn_wdata;
  assign cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
  assign wr_ready  = sel ? b_wr_ready  : a_wr_ready;
  assign rd_valid  = sel ? b_rd_valid  : a_rd_valid;
  assign rd_data   = sel ? b_rd_data   : a_rd_data;
  assign busy      = sel ? b_busy      : a_busy;
  assign done      = sel ? b_done      : a_done;
  assign err       = sel ? b_err       : a_err;
  assign dn_read   = sel ? b_dn_read   : a_dn_read;
  assign dn_write  = sel ? b_dn_write  : a_dn_write;
  assign dn_a0     = sel ? b_dn_a0     : a_dn_a0;
  assign dn_wdata  = sel ? b_dn_wdata  : a_dn_wdata;

  usb_reg_burst_engine #(.AUTO_INC(1), .TIMEOUT(64)) dut_a (
    .clk(clk), .rst(rst),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(cmd_write),
    .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(a_wr_ready), .wr_data(wr_data),
    .rd_valid(a_rd_valid), .rd_ready(rd_ready), .rd_data(a_rd_data),
    .busy(a_busy), .done(a_done), .err(a_err),
    .dn_read(a_dn_read), .dn_write(a_dn_write), .dn_a0(a_dn_a0),
    .dn_wdata(a_dn_wdata), .dn_stall(a_dn_stall), .dn_rdata(dn_rdata)
  );

  usb_reg_burst_engine #(.AUTO_INC(0), .TIMEOUT(64)) dut_b (
    .clk(clk), .rst(rst),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(cmd_write),
    .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_data(wr_data),
    .rd_valid(b_rd_valid), .rd_ready(rd_ready), .rd_data(b_rd_data),
    .busy(b_busy), .done(b_done), .err(b_err),
    .dn_read(b_dn_read), .dn_write(b_dn_write), .dn_a0(b_dn_a0),
    .dn_wdata(b_dn_wdata), .dn_stall(b_dn_stall), .dn_rdata(dn_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic w; logic a0; logic [7:0] d; } acc_t;
  typedef struct {
    bit sel; bit w; logic [7:0] rg; logic [7:0] len;
    logic [7:0] b0; logic [7:0] b1; logic [7:0] b2;
    int stall; int rd_hold; int exp_acc; int exp_done;
  } vec_t;

  acc_t       exp_acc_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] rdata_q[$];
  logic [7:0] wr_q[$];

  int n_checks = 0, n_fail = 0;
  int n_acc = 0, n_done = 0, n_errp = 0, n_req = 0, n_wrr = 0;
  int stall_delay = 2, hold = 0, rd_hold = 0;
  bit model_en = 1'b1, prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Downstream byte-controller model
  always @(negedge clk) begin
    if (rst) begin
      dn_stall = 1'b0;
      hold = 0;
    end else if (!dn_stall) begin
      if (model_en && (dn_read || dn_write)) begin
        acc_t e;
        n_acc++;
        check("one_req", {31'd0, dn_read & dn_write}, 0);
        if (exp_acc_q.size() == 0) begin
          check("extra_access", n_acc, 0);
        end else begin
          e = exp_acc_q.pop_front();
          check("acc_write", {31'd0, dn_write}, {31'd0, e.w});
          check("acc_a0", {31'd0, dn_a0}, {31'd0, e.a0});
          if (e.w) check("acc_wdata", {24'd0, dn_wdata}, {24'd0, e.d});
        end
        if (dn_read) dn_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 8'hEE;
        dn_stall = 1'b1;
        hold = stall_delay - 1;
      end
    end else if (hold <= 0) begin
      dn_stall = 1'b0;
    end else begin
      hold--;
    end
  end

  // Write-byte feeder
  always @(negedge clk) begin
    if (!rst && wr_ready && wr_q.size() > 0) begin
      wr_valid = 1'b1;
      wr_data = wr_q.pop_front();
    end else begin
      wr_valid = 1'b0;
    end
  end

  // Read-byte consumer
  always @(negedge clk) begin
    if (rst) begin
      rd_ready = 1'b0;
    end else if (rd_valid) begin
      if (exp_rd_q.size() == 0) check("extra_rd", {24'd0, rd_data}, 32'hFFFF_FFFF);
      else check("rd_data", {24'd0, rd_data}, {24'd0, exp_rd_q[0]});
      check("no_read_while_push", {31'd0, dn_read}, 0);
      if (rd_hold > 0) begin
        rd_hold--;
        rd_ready = 1'b0;
      end else if (!rd_ready) begin
        rd_ready = 1'b1;
        if (exp_rd_q.size() > 0) exp_rd_q.delete(0);
      end
    end else begin
      rd_ready = 1'b0;
    end
  end

  // Status monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (done) n_done++;
      if (err) n_errp++;
      if (dn_read || dn_write) n_req++;
      if (wr_ready) n_wrr++;
      if (prev_done) check("busy_after_done", {31'd0, busy}, 0);
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic push_acc(input logic w, input logic a0, input logic [7:0] d);
    acc_t e;
    e.w = w; e.a0 = a0; e.d = d;
    exp_acc_q.push_back(e);
  endtask

  task automatic issue_cmd(input bit w, input logic [7:0] rg, input logic [7:0] len);
    @(negedge clk);
    check("cmd_ready_idle", {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_reg = rg; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_cmd", {31'd0, busy}, 1);
    check("cmd_ready_busy", {31'd0, cmd_ready}, 0);
  endtask

  task automatic wait_idle(input int bound);
    for (int c = 0; c < bound; c++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("idle_bound", {31'd0, busy}, 0);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] bytes [3];
    int acc0, done0, errp0;
    bit ai;
    sel = v.sel;
    ai = !v.sel;
    stall_delay = v.stall;
    rd_hold = v.rd_hold;
    bytes[0] = v.b0; bytes[1] = v.b1; bytes[2] = v.b2;
    push_acc(1'b1, 1'b0, v.rg);
    for (int i = 0; i < int'(v.len); i++) begin
      if (!ai && i > 0) push_acc(1'b1, 1'b0, v.rg + 8'(i));
      push_acc(v.w, 1'b1, bytes[i]);
      if (v.w) wr_q.push_back(bytes[i]);
      else begin
        rdata_q.push_back(bytes[i]);
        exp_rd_q.push_back(bytes[i]);
      end
    end
    acc0 = n_acc; done0 = n_done; errp0 = n_errp;
    issue_cmd(v.w, v.rg, v.len);
    wait_idle(3000);
    check({tag, "_accesses"}, n_acc - acc0, v.exp_acc);
    check({tag, "_done"}, n_done - done0, v.exp_done);
    check({tag, "_err"}, n_errp - errp0, 0);
    check({tag, "_acc_left"}, exp_acc_q.size(), 0);
    check({tag, "_rd_left"}, exp_rd_q.size(), 0);
  endtask

  vec_t vecs [6];

  initial begin
    int acc0, done0, errp0, req0, wrr0;
    bit found;
    vecs[0] = '{sel:0, w:1, rg:8'h10, len:8'd3, b0:8'hA1, b1:8'hB2, b2:8'hC3,
                stall:12, rd_hold:0, exp_acc:4, exp_done:1};
    vecs[1] = '{sel:0, w:0, rg:8'h20, len:8'd2, b0:8'h5A, b1:8'h6B, b2:8'h00,
                stall:3, rd_hold:5, exp_acc:3, exp_done:1};
    vecs[2] = '{sel:1, w:1, rg:8'hFE, len:8'd3, b0:8'h11, b1:8'h22, b2:8'h33,
                stall:2, rd_hold:0, exp_acc:6, exp_done:1};
    vecs[3] = '{sel:0, w:1, rg:8'h05, len:8'd0, b0:8'h00, b1:8'h00, b2:8'h00,
                stall:2, rd_hold:0, exp_acc:1, exp_done:1};
    vecs[4] = '{sel:1, w:0, rg:8'hFF, len:8'd2, b0:8'h77, b1:8'h88, b2:8'h00,
                stall:4, rd_hold:2, exp_acc:4, exp_done:1};
    vecs[5] = '{sel:0, w:0, rg:8'h30, len:8'd1, b0:8'h9C, b1:8'h00, b2:8'h00,
                stall:1, rd_hold:0, exp_acc:2, exp_done:1};

    // Reset state
    #12;
    check("rst_a_outputs",
          {21'd0, a_cmd_ready, a_wr_ready, a_rd_valid, a_busy, a_done, a_err,
           a_dn_read, a_dn_write, a_dn_a0, (a_dn_wdata != 0), (a_rd_data != 0)}, 0);
    check("rst_b_outputs",
          {21'd0, b_cmd_ready, b_wr_ready, b_rd_valid, b_busy, b_done, b_err,
           b_dn_read, b_dn_write, b_dn_a0, (b_dn_wdata != 0), (b_rd_data != 0)}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("cmd_ready_after_rst", {30'd0, a_cmd_ready, b_cmd_ready}, 3);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // len=0 must never request a write byte
    wrr0 = n_wrr;
    run_vec(vecs[3], "len0_again");
    check("len0_no_wr_ready", n_wrr - wrr0, 0);

    // Timeout: downstream never stalls
    sel = 1'b0;
    model_en = 1'b0;
    done0 = n_done; errp0 = n_errp; req0 = n_req;
    issue_cmd(1'b1, 8'h40, 8'd1);
    wait_idle(500);
    check("tmo_req_cycles", n_req - req0, 64);
    check("tmo_err", n_errp - errp0, 1);
    check("tmo_done", n_done - done0, 0);
    model_en = 1'b1;
    run_vec(vecs[3], "after_tmo");

    // Asynchronous reset while a data write waits on the chip
    sel = 1'b0;
    stall_delay = 12;
    push_acc(1'b1, 1'b0, 8'h50);
    push_acc(1'b1, 1'b1, 8'hD1);
    push_acc(1'b1, 1'b1, 8'hD2);
    wr_q.push_back(8'hD1); wr_q.push_back(8'hD2);
    done0 = n_done; errp0 = n_errp; acc0 = n_acc;
    issue_cmd(1'b1, 8'h50, 8'd2);
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (dn_write && dn_a0) found = 1'b1;
    end
    check("reach_data_req", {31'd0, found}, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_dn_write", {31'd0, a_dn_write}, 0);
    check("rst_mid_busy", {31'd0, a_busy}, 0);
    check("rst_mid_accesses", n_acc - acc0, 2);
    exp_acc_q.delete(); wr_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_no_done", n_done - done0, 0);
    check("rst_mid_no_err", n_errp - errp0, 0);
    run_vec(vecs[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
